dnn_batch_sched: RTL and testbench
==================================

DNN_BATCH_SCHED -- requirements
Module: dnn_batch_sched

Interface
REQ-001 Parameter CNT_WIDTH, default 8: width of the batch count and the image index.
REQ-002 Parameter TIMEOUT_CYCLES, default 20'd200000: maximum WAIT_DONE cycles before an inference is declared failed.
REQ-003 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port cmd_valid/cmd_ready, input/output, 1/1: batch-command handshake; transfer when both are high.
REQ-006 Port cmd_count, input, CNT_WIDTH: number of images in the batch; sampled on transfer.
REQ-007 Port img_req/img_ack, output/input, 1/1: request for the loader to place the next image in activation memory; ack ends the load.
REQ-008 Port img_index, output, CNT_WIDTH: index of the image requested; valid while img_req is high.
REQ-009 Port eng_reset/eng_start, output/output, 1/1: single-cycle pulses to the sigmoid inference engine.
REQ-010 Port eng_done, input, 1: engine completion level.
REQ-011 Port eng_out, input, signed [3:0] x10: engine class scores.
REQ-012 Port res_valid/res_ready, output/input, 1/1: result handshake.
REQ-013 Port res_class/res_score/res_index/res_err, output, 4/4 signed/CNT_WIDTH/1: winning class, its score, image index and timeout flag.
REQ-014 Port busy/batch_done, output/output, 1/1: busy is high when the state is not IDLE; batch_done is a 1-cycle pulse.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, LOAD, ENG_RST, ENG_START, WAIT_DONE, ARGMAX, RESULT.
REQ-016 IDLE: cmd_ready=1; on transfer, latch cmd_count and clear idx to 0. If count=0, pulse batch_done next cycle and stay in IDLE; otherwise go to LOAD.
REQ-017 LOAD: img_req=1 and img_index=idx. Hold until img_ack is sampled high, then go to ENG_RST. img_ack outside LOAD SHALL be ignored.
REQ-018 ENG_RST: eng_reset=1 for exactly one cycle, then ENG_START. ENG_START: eng_start=1 for exactly one cycle, then WAIT_DONE.
REQ-019 WAIT_DONE: eng_done is sampled only in this state; stale done from a prior run is cleared by the ENG_RST pulse. The timeout counter increments every cycle here.
REQ-020 When eng_done=1 is sampled, capture all ten eng_out into registers, set best=out[0] and bidx=0, and go to ARGMAX.
REQ-021 ARGMAX: compare one element per cycle (i=1..9, 9 cycles) using a signed compare. Replace only if out[i] > best, so ties resolve to the lowest index. Then go to RESULT.
REQ-022 Latency: done sampled in cycle D gives res_valid=1 in cycle D+10. img_ack in cycle A gives eng_reset in A+1 and eng_start in A+2.
REQ-023 Timeout: if the counter reaches TIMEOUT_CYCLES without done, go to RESULT with res_err=1, res_class=4'hF and res_score=0. An eng_reset pulse SHALL be issued in that same transition cycle.
REQ-024 RESULT: res_valid is held high and res_* are held stable until res_ready=1.
REQ-025 On the RESULT handshake: if idx == count-1, pulse batch_done and go to IDLE. Otherwise increment idx and go to LOAD.
REQ-026 cmd_valid while busy SHALL be ignored (cmd_ready=0). res_ready while res_valid=0 has no effect.
REQ-027 eng_out width rule: scores are signed 4-bit; res_score equals the selected score bit-exact.

Reset
REQ-028 rst=1 SHALL force state IDLE from any state, including mid-inference, and clear all counters.
REQ-029 Reset values: cmd_ready=1 the cycle after reset. img_req, eng_reset, eng_start, res_valid, res_err, busy and batch_done = 0. res_class, res_score, res_index and img_index = 0.
REQ-030 Reset during WAIT_DONE SHALL NOT generate eng_reset; the engine shares rst.

Verification
REQ-031 Batch of 1, ack after 3 cycles, done 50 cycles after start, eng_out={0:-2,3:5,7:5,others:-8} -> res_class=3, res_score=5, res_index=0, res_err=0, followed by a batch_done pulse.
REQ-032 Batch of 3 with res_ready held low for 4 cycles on result 1 -> res_* stable throughout; img_index sequence 0,1,2; exactly one batch_done.
REQ-033 eng_done never asserted, TIMEOUT_CYCLES=16 -> res_err=1, res_class=4'hF, and one eng_reset pulse at the timeout transition.
REQ-034 cmd_count=0 -> no img_req, batch_done one cycle after transfer, busy stays 0.
REQ-035 rst asserted in WAIT_DONE and in RESULT -> next cycle IDLE with every output at its reset value; a new command then runs normally.
REQ-036 All eng_out=-8 -> res_class=0, res_score=-8; cmd_valid pulsed while busy is not accepted.

Source files
------------

// File: rtl/dnn_batch_sched.sv
// dnn_batch_sched: walks a batch of images through a sigmoid inference
// engine, then picks the top class of each result with a serial argmax.
module dnn_batch_sched #(
  parameter int          CNT_WIDTH      = 8,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  output logic                 img_req,
  input  logic                 img_ack,
  output logic [CNT_WIDTH-1:0] img_index,
  output logic                 eng_reset,
  output logic                 eng_start,
  input  logic                 eng_done,
  input  logic [39:0]          eng_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_class,
  output logic [3:0]           res_score,
  output logic [CNT_WIDTH-1:0] res_index,
  output logic                 res_err,
  output logic                 busy,
  output logic                 batch_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ENG_RST, ENG_START,
    WAIT_DONE, ARGMAX, RESULT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [19:0]          tmo_q, tmo_d;
  logic [39:0]          outs_q, outs_d;
  logic [3:0]           best_q, best_d;
  logic [3:0]           bidx_q, bidx_d;
  logic [3:0]           ai_q, ai_d;
  logic [3:0]           cls_q, cls_d;
  logic [3:0]           score_q, score_d;
  logic                 err_q, err_d;
  logic                 bdone_q, bdone_d;
  logic                 tmo_hit;
  logic [3:0]           cur;
  logic                 win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      outs_q  <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      ai_q    <= '0;
      cls_q   <= '0;
      score_q <= '0;
      err_q   <= 1'b0;
      bdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      outs_q  <= outs_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      ai_q    <= ai_d;
      cls_q   <= cls_d;
      score_q <= score_d;
      err_q   <= err_d;
      bdone_q <= bdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = '0;
    outs_d  = outs_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    ai_d    = ai_q;
    cls_d   = cls_q;
    score_d = score_q;
    err_d   = err_q;
    bdone_d = 1'b0;
    tmo_hit = 1'b0;
    cur     = outs_q[{ai_q, 2'b00} +: 4];
    win     = $signed(cur) > $signed(best_q);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d = cmd_count;
          idx_d = '0;
          if (cmd_count == '0) bdone_d = 1'b1;
          else state_d = LOAD;
        end
      end
      LOAD:      if (img_ack) state_d = ENG_RST;
      ENG_RST:   state_d = ENG_START;
      ENG_START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        tmo_d = tmo_q + 20'd1;
        if (eng_done) begin
          outs_d  = eng_out;
          best_d  = eng_out[3:0];
          bidx_d  = 4'd0;
          ai_d    = 4'd1;
          state_d = ARGMAX;
        end else if (tmo_q == TIMEOUT_CYCLES - 20'd1) begin
          // engine is kicked back to a clean state as we give up
          tmo_hit = 1'b1;
          cls_d   = 4'hF;
          score_d = 4'd0;
          err_d   = 1'b1;
          state_d = RESULT;
        end
      end
      ARGMAX: begin
        if (win) begin
          best_d = cur;
          bidx_d = ai_q;
        end
        ai_d = ai_q + 4'd1;
        if (ai_q == 4'd9) begin
          cls_d   = win ? ai_q : bidx_q;
          score_d = win ? cur : best_q;
          err_d   = 1'b0;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          if (idx_q == cnt_q - CNT_WIDTH'(1)) begin
            bdone_d = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + CNT_WIDTH'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign img_req    = (state_q == LOAD);
  assign img_index  = idx_q;
  assign eng_reset  = !rst &&
                      ((state_q == ENG_RST) || tmo_hit);
  assign eng_start  = (state_q == ENG_START);
  assign res_valid  = (state_q == RESULT);
  assign res_class  = cls_q;
  assign res_score  = score_q;
  assign res_index  = idx_q;
  assign res_err    = err_q;
  assign batch_done = bdone_q;

endmodule

// File: tb/tb_dnn_batch_sched.sv
// tb_dnn_batch_sched: directed checks of dnn_batch_sched
// u_a runs the functional batches, u_b the short-timeout case.
module tb_dnn_batch_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cv_a, cv_b;
  logic [7:0]  cmd_count;
  logic        img_ack, eng_done, res_ready;
  logic [39:0] eng_out;

  logic       a_cr, a_ir, a_er, a_es, a_rv, a_err, a_busy, a_bd;
  logic [7:0] a_ii, a_ri;
  logic [3:0] a_cls, a_sc;
  logic       b_cr, b_ir, b_er, b_es, b_rv, b_err, b_busy, b_bd;
  logic [7:0] b_ii, b_ri;
  logic [3:0] b_cls, b_sc;

  dnn_batch_sched u_a (
    .clk(clk), .rst(rst),
    .cmd_valid(cv_a), .cmd_ready(a_cr), .cmd_count(cmd_count),
    .img_req(a_ir), .img_ack(img_ack), .img_index(a_ii),
    .eng_reset(a_er), .eng_start(a_es),
    .eng_done(eng_done), .eng_out(eng_out),
    .res_valid(a_rv), .res_ready(res_ready),
    .res_class(a_cls), .res_score(a_sc), .res_index(a_ri),
    .res_err(a_err), .busy(a_busy), .batch_done(a_bd)
  );

  dnn_batch_sched #(.TIMEOUT_CYCLES(20'd16)) u_b (
    .clk(clk), .rst(rst),
    .cmd_valid(cv_b), .cmd_ready(b_cr), .cmd_count(cmd_count),
    .img_req(b_ir), .img_ack(img_ack), .img_index(b_ii),
    .eng_reset(b_er), .eng_start(b_es),
    .eng_done(eng_done), .eng_out(eng_out),
    .res_valid(b_rv), .res_ready(res_ready),
    .res_class(b_cls), .res_score(b_sc), .res_index(b_ri),
    .res_err(b_err), .busy(b_busy), .batch_done(b_bd)
  );

  int n_chk = 0;
  int n_err = 0;
  int a_bd_cnt = 0;
  int b_er_cnt = 0;

  always @(posedge clk) begin
    if (a_bd) a_bd_cnt++;
    if (b_er) b_er_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] fill(input logic [3:0] v);
    return {10{v}};
  endfunction

  task automatic chk_rst();
    chk("rst_cmd_ready", a_cr, 1);
    chk("rst_img_req", a_ir, 0);
    chk("rst_eng_reset", a_er, 0);
    chk("rst_eng_start", a_es, 0);
    chk("rst_res_valid", a_rv, 0);
    chk("rst_res_err", a_err, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_batch_done", a_bd, 0);
    chk("rst_res_class", a_cls, 0);
    chk("rst_res_score", a_sc, 0);
    chk("rst_res_index", a_ri, 0);
    chk("rst_img_index", a_ii, 0);
  endtask

  task automatic send_a(input logic [7:0] n);
    cv_a = 1'b1;
    cmd_count = n;
    chk("cmd_ready", a_cr, 1);
    cyc();
    cv_a = 1'b0;
  endtask

  // One image on u_a; kill=1 resets in RESULT instead of handshaking.
  task automatic do_img(input logic [7:0] xidx,
                        input int ack_dly,
                        input int done_dly,
                        input logic [39:0] outs,
                        input logic [3:0] xcls,
                        input logic [3:0] xsc,
                        input int hold,
                        input bit last,
                        input bit kill);
    int k;
    k = 0;
    while (!a_ir && k < 20) begin
      cyc();
      k++;
    end
    chk("img_req", a_ir, 1);
    chk("img_index", a_ii, xidx);
    repeat (ack_dly) cyc();
    img_ack = 1'b1;
    cyc();
    img_ack = 1'b0;
    chk("eng_reset_A1", a_er, 1);
    cyc();
    chk("eng_start_A2", a_es, 1);
    repeat (done_dly) cyc();
    eng_out  = outs;
    eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    repeat (8) cyc();
    chk("res_valid_D9", a_rv, 0);
    cyc();
    chk("res_valid_D10", a_rv, 1);
    chk("res_class", a_cls, xcls);
    chk("res_score", a_sc, xsc);
    chk("res_index", a_ri, xidx);
    chk("res_err", a_err, 0);
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("hold_valid", a_rv, 1);
      chk("hold_class", a_cls, xcls);
      chk("hold_score", a_sc, xsc);
      chk("hold_index", a_ri, xidx);
    end
    if (kill) begin
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_rst();
    end else begin
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
      chk("batch_done", a_bd, 32'(last));
      chk("busy_after", a_busy, 32'(!last));
    end
  endtask

  logic [39:0] v1, v2a, v2b, v2c, v8;
  int bd0, e0;

  initial begin
    rst = 1'b1;
    cv_a = 1'b0;
    cv_b = 1'b0;
    cmd_count = '0;
    img_ack = 1'b0;
    eng_done = 1'b0;
    res_ready = 1'b0;
    eng_out = '0;

    v1 = fill(4'h8);
    v1[3:0] = 4'hE;
    v1[15:12] = 4'h5;
    v1[31:28] = 4'h5;
    v2a = fill(4'h0);
    v2a[39:36] = 4'h7;
    v2b = fill(4'hF);
    v2b[3:0] = 4'hB;
    v2b[19:16] = 4'h3;
    v2c = fill(4'h2);
    v8 = fill(4'h8);

    repeat (2) cyc();
    rst = 1'b0;
    chk_rst();

    // single image, tie between classes 3 and 7
    bd0 = a_bd_cnt;
    send_a(8'd1);
    do_img(8'd0, 3, 50, v1, 4'd3, 4'd5, 0, 1, 0);
    cyc();
    chk("bd_pulse_len", a_bd, 0);
    chk("bd_count_1", a_bd_cnt - bd0, 1);

    // batch of three, result 1 back-pressured
    bd0 = a_bd_cnt;
    send_a(8'd3);
    do_img(8'd0, 1, 5, v2a, 4'd9, 4'd7, 0, 0, 0);
    do_img(8'd1, 2, 3, v2b, 4'd4, 4'd3, 4, 0, 0);
    do_img(8'd2, 0, 1, v2c, 4'd0, 4'd2, 0, 1, 0);
    cyc();
    chk("bd_count_3", a_bd_cnt - bd0, 1);

    // empty batch
    cv_a = 1'b1;
    cmd_count = 8'd0;
    chk("cmd_ready_z", a_cr, 1);
    cyc();
    cv_a = 1'b0;
    chk("z_batch_done", a_bd, 1);
    chk("z_busy", a_busy, 0);
    chk("z_img_req", a_ir, 0);
    cyc();
    chk("z_bd_low", a_bd, 0);
    chk("z_busy2", a_busy, 0);
    chk("z_img_req2", a_ir, 0);

    // timeout on u_b (16 cycles)
    cv_b = 1'b1;
    cmd_count = 8'd1;
    cyc();
    cv_b = 1'b0;
    chk("t_img_req", b_ir, 1);
    img_ack = 1'b1;
    cyc();
    img_ack = 1'b0;
    chk("t_eng_reset", b_er, 1);
    cyc();
    chk("t_eng_start", b_es, 1);
    e0 = b_er_cnt;
    repeat (15) cyc();
    chk("t_er_pre", b_er, 0);
    chk("t_rv_pre", b_rv, 0);
    cyc();
    chk("t_er_hit", b_er, 1);
    chk("t_busy", b_busy, 1);
    cyc();
    chk("t_res_valid", b_rv, 1);
    chk("t_res_err", b_err, 1);
    chk("t_res_class", b_cls, 4'hF);
    chk("t_res_score", b_sc, 0);
    chk("t_res_index", b_ri, 0);
    chk("t_er_count", b_er_cnt - e0, 1);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("t_batch_done", b_bd, 1);
    chk("t_busy_end", b_busy, 0);

    // reset mid-inference in WAIT_DONE
    send_a(8'd1);
    img_ack = 1'b1;
    cyc();
    img_ack = 1'b0;
    cyc();
    repeat (5) cyc();
    chk("w_busy", a_busy, 1);
    rst = 1'b1;
    chk("w_no_eng_reset", a_er, 0);
    cyc();
    rst = 1'b0;
    chk_rst();

    // reset while holding a result
    send_a(8'd1);
    do_img(8'd0, 1, 4, v1, 4'd3, 4'd5, 2, 1, 1);

    // all scores -8, extra command while busy is dropped
    send_a(8'd1);
    cv_a = 1'b1;
    cmd_count = 8'd5;
    chk("busy_cmd_ready", a_cr, 0);
    cyc();
    cv_a = 1'b0;
    do_img(8'd0, 2, 4, v8, 4'd0, 4'h8, 0, 1, 0);
    cyc();
    chk("end_idle", a_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
